rf_write_arbiter: RTL and testbench



---
 rtl/rf_pkg.sv | 7 +
 rtl/rf_write_arbiter_rr_arb2.sv | 20 ++
 rtl/rf_write_arbiter.sv | 84 ++++++++
 tb/tb_rf_write_arbiter.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file constants and sequencer state encoding
package rf_pkg;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NREG = 1 << AW;
  typedef enum logic {INIT, RUN} state_t;
endpackage

// File: rtl/rf_write_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin arbiter; the loser of the last transfer wins ties
module rr_arb2 (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);
  logic last_q, last_d;
  // one-hot grant and next last-grant, which moves only on a transfer
  always_comb begin
    grant = &valid ? (last_q ? 2'b01 : 2'b10) : valid;
    last_d = accept ? grant[1] : last_q;
  end
  // last-grant register; reset favours requester 0 on the first tie
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) last_q <= 1'b1;
    else last_q <= last_d;
  end
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: clears the register file after reset, then shares its write port between two requesters with read forwarding
module rf_write_arbiter import rf_pkg::*; #(
  parameter int DW = rf_pkg::DW,
  parameter int AW = rf_pkg::AW,
  parameter logic [DW-1:0] INIT_VALUE = '0
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  input  logic [AW-1:0] rd1_addr,
  input  logic [AW-1:0] rd2_addr,
  input  logic [DW-1:0] rf_rd1_data,
  input  logic [DW-1:0] rf_rd2_data,
  output logic [DW-1:0] rd1_data,
  output logic [DW-1:0] rd2_data,
  output logic          init_done
);
  state_t state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d, waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic we_q, we_d, done_q, done_d;
  logic [1:0] grant;
  logic accept;
  assign accept = done_q & (req0_valid | req1_valid);
  rr_arb2 u_arb (
    .Clk    (Clk),
    .Rst    (Rst),
    .valid  ({req1_valid, req0_valid}),
    .accept (accept),
    .grant  (grant)
  );
  assign req0_ready = done_q & grant[0];
  assign req1_ready = done_q & grant[1];
  assign rf_we = we_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;
  assign init_done = done_q;
  assign rd1_data = (we_q && waddr_q == rd1_addr) ? wdata_q : rf_rd1_data;
  assign rd2_data = (we_q && waddr_q == rd2_addr) ? wdata_q : rf_rd2_data;
  // clear sweep during INIT, otherwise register the granted request
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    done_d = state_q == RUN;
    we_d = accept;
    waddr_d = accept ? (grant[1] ? req1_addr : req0_addr) : waddr_q;
    wdata_d = accept ? (grant[1] ? req1_data : req0_data) : wdata_q;
    if (state_q == INIT) begin
      we_d = 1'b1;
      waddr_d = cnt_q;
      wdata_d = INIT_VALUE;
      cnt_d = cnt_q + 1'b1;
      state_d = &cnt_q ? RUN : INIT;
    end
  end
  // state and write-port registers; reset drops any pending write at once
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= INIT;
      cnt_q <= '0;
      done_q <= 1'b0;
      we_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
      we_q <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed self-checking bench for rf_write_arbiter
module tb_rf_write_arbiter;
  logic Clk = 0, Rst = 0;
  logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [3:0] req0_addr = 0, req1_addr = 0, rd1_addr = 0, rd2_addr = 0, rf_waddr;
  logic [15:0] req0_data = 0, req1_data = 0, rf_rd1_data = 0, rf_rd2_data = 0;
  logic [15:0] rf_wdata, rd1_data, rd2_data;
  logic rf_we, init_done;
  logic [15:0] mem [16];
  int n_cmp = 0, n_err = 0;
  rf_write_arbiter dut (
    .Clk(Clk), .Rst(Rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rd1_addr(rd1_addr), .rd2_addr(rd2_addr), .rf_rd1_data(rf_rd1_data), .rf_rd2_data(rf_rd2_data),
    .rd1_data(rd1_data), .rd2_data(rd2_data), .init_done(init_done)
  );
  always #5 Clk = ~Clk;
  always @(posedge Clk) if (rf_we) mem[rf_waddr] <= rf_wdata;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic edge1;
    @(posedge Clk);
    #1;
  endtask
  task automatic init_seq;
    for (int i = 0; i < 16; i++) begin
      edge1;
      chk("init_we", 32'(rf_we), 1);
      chk("init_waddr", 32'(rf_waddr), 32'(i));
      chk("init_wdata", 32'(rf_wdata), 0);
      chk("init_done_low", 32'(init_done), 0);
      chk("init_ready0", 32'(req0_ready), 0);
      chk("init_ready1", 32'(req1_ready), 0);
      rd1_addr = 4'(i);
      rf_rd1_data = 16'hFFFF;
      #1;
      chk("init_fwd", 32'(rd1_data), 0);
    end
  endtask
  initial begin
    #2;
    chk("rst_we", 32'(rf_we), 0);
    chk("rst_done", 32'(init_done), 0);
    chk("rst_waddr", 32'(rf_waddr), 0);
    chk("rst_wdata", 32'(rf_wdata), 0);
    edge1;
    edge1;
    chk("rst_hold_we", 32'(rf_we), 0);
    req1_valid = 1; req1_addr = 4; req1_data = 16'h4444;
    Rst = 1;
    init_seq;
    edge1;
    chk("done_rise", 32'(init_done), 1);
    chk("idle_we", 32'(rf_we), 0);
    chk("r1_ready", 32'(req1_ready), 1);
    edge1;
    req1_valid = 0;
    chk("r1_we", 32'(rf_we), 1);
    chk("r1_waddr", 32'(rf_waddr), 4);
    chk("r1_wdata", 32'(rf_wdata), 16'h4444);
    req0_valid = 1; req0_addr = 1; req0_data = 16'h1111;
    req1_valid = 1; req1_addr = 2; req1_data = 16'h2222;
    #1;
    chk("cont_ready0_a", 32'(req0_ready), 1);
    chk("cont_ready1_a", 32'(req1_ready), 0);
    edge1;
    chk("cont_waddr_1", 32'(rf_waddr), 1);
    chk("cont_wdata_1", 32'(rf_wdata), 16'h1111);
    chk("cont_ready0_b", 32'(req0_ready), 0);
    chk("cont_ready1_b", 32'(req1_ready), 1);
    edge1;
    chk("cont_waddr_2", 32'(rf_waddr), 2);
    chk("cont_wdata_2", 32'(rf_wdata), 16'h2222);
    chk("cont_ready0_c", 32'(req0_ready), 1);
    edge1;
    chk("cont_waddr_3", 32'(rf_waddr), 1);
    chk("cont_ready1_d", 32'(req1_ready), 1);
    edge1;
    req0_valid = 0; req1_valid = 0;
    chk("cont_waddr_4", 32'(rf_waddr), 2);
    chk("cont_we_4", 32'(rf_we), 1);
    edge1;
    chk("cont_idle_we", 32'(rf_we), 0);
    req0_valid = 1; req0_addr = 3; req0_data = 16'h00AB;
    #1;
    chk("r0_ready", 32'(req0_ready), 1);
    chk("r0_ready1", 32'(req1_ready), 0);
    edge1;
    req0_valid = 0;
    chk("r0_we", 32'(rf_we), 1);
    chk("r0_waddr", 32'(rf_waddr), 3);
    chk("r0_wdata", 32'(rf_wdata), 16'h00AB);
    edge1;
    chk("r0_we_drop", 32'(rf_we), 0);
    req0_valid = 1; req0_addr = 5; req0_data = 16'h0F0F;
    edge1;
    req0_valid = 0;
    rd1_addr = 5; rd2_addr = 5; rf_rd1_data = 0; rf_rd2_data = 16'h1234;
    #1;
    chk("fwd_rd1", 32'(rd1_data), 16'h0F0F);
    chk("fwd_rd2", 32'(rd2_data), 16'h0F0F);
    rd1_addr = 6; rf_rd1_data = 16'hBEEF;
    #1;
    chk("fwd_rd1_miss", 32'(rd1_data), 16'hBEEF);
    chk("fwd_rd2_keep", 32'(rd2_data), 16'h0F0F);
    edge1;
    chk("fwd_rd2_off", 32'(rd2_data), 16'h1234);
    req0_valid = 1; req0_addr = 8; req0_data = 16'hDEAD;
    edge1;
    req0_valid = 0;
    chk("pre_rst_we", 32'(rf_we), 1);
    Rst = 0;
    #1;
    chk("mid_rst_we", 32'(rf_we), 0);
    chk("mid_rst_done", 32'(init_done), 0);
    chk("mid_rst_ready", 32'(req0_ready), 0);
    #1;
    Rst = 1;
    init_seq;
    edge1;
    chk("redone", 32'(init_done), 1);
    chk("dropped_mem8", 32'(mem[8]), 0);
    req0_valid = 1; req0_addr = 7; req0_data = 16'h0001;
    req1_valid = 1; req1_addr = 7; req1_data = 16'h0002;
    #1;
    chk("same_ready0", 32'(req0_ready), 1);
    edge1;
    req0_valid = 0;
    chk("same_waddr_a", 32'(rf_waddr), 7);
    chk("same_wdata_a", 32'(rf_wdata), 16'h0001);
    chk("same_ready1", 32'(req1_ready), 1);
    edge1;
    req1_valid = 0;
    chk("same_waddr_b", 32'(rf_waddr), 7);
    chk("same_wdata_b", 32'(rf_wdata), 16'h0002);
    edge1;
    chk("same_we_off", 32'(rf_we), 0);
    chk("same_final", 32'(mem[7]), 16'h0002);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
